// File: rtl/codes_bin2ascii_pkg.sv
// Shared types and constants for the binary-to-ASCII decimal streamer.
// ndigits() sizes the BCD register for a given binary input width.
package codes_bin2ascii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    EMIT
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // 2^n is never a power of ten, so 2^n-1 has floor(n*log10(2))+1 digits.
  function automatic int ndigits(input int nbits);
    return (nbits * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/codes_bcd_add3_step.sv
// Double-dabble correction: every BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module codes_bcd_add3_step #(
  parameter int ND = 3
) (
  input  logic [4*ND-1:0] bcd_i,
  output logic [4*ND-1:0] bcd_o
);

  for (genvar g = 0; g < ND; g++) begin : g_digit
    logic [3:0] digit;
    assign digit = bcd_i[4*g +: 4];
    assign bcd_o[4*g +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/codes_bin2ascii_stream.sv
// Sequential binary-to-ASCII decimal converter: one double-dabble step per
// cycle, then streams digits MSD first over a val/rdy output.
module codes_bin2ascii_stream
  import codes_bin2ascii_pkg::*;
#(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_,
  input  logic               zpad,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [7:0]         out,
  output logic               out_last
);

  localparam int ND = ndigits(p_nbits);
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(p_nbits + 1);
  localparam int PW = (ND > 1) ? $clog2(ND) : 1;

  state_e               state_q, state_d;
  logic [p_nbits-1:0]   bin_q, bin_d, bin_shift;
  logic [BW-1:0]        bcd_q, bcd_d, bcd_adj, bcd_shift;
  logic                 zpad_q, zpad_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d, msd;
  logic [ND-1:0][3:0]   digits;

  codes_bcd_add3_step #(.ND(ND)) u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  assign {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;

  // Highest non-zero digit of the final BCD value; 0 when the value is zero.
  always_comb begin
    msd = '0;
    for (int i = 0; i < ND; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) msd = PW'(i);
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    zpad_d  = zpad_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (in_val) begin
          bin_d   = in_;
          bcd_d   = '0;
          zpad_d  = zpad;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(p_nbits - 1)) begin
          state_d = EMIT;
          ptr_d   = zpad_q ? PW'(ND - 1) : msd;
        end
      end
      EMIT: begin
        if (out_rdy) begin
          if (ptr_q == '0) state_d = IDLE;
          else             ptr_d   = ptr_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      zpad_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      zpad_q  <= zpad_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign digits   = bcd_q;
  assign in_rdy   = (state_q == IDLE);
  assign out_val  = (state_q == EMIT);
  assign out      = out_val ? (ASCII_ZERO + {4'd0, digits[ptr_q]}) : 8'h00;
  assign out_last = out_val && (ptr_q == '0);

endmodule

// File: tb/tb_codes_bin2ascii_stream.sv
// Self-checking bench: three widths (4, 8, 16) against a decimal-string model
// built with integer division; directed cases followed by random values.
module tb_codes_bin2ascii_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_val_r;
  logic [15:0] in_bus;
  logic        zpad_r;
  logic        out_rdy;
  logic [2:0]  in_rdy_w, out_val_w, out_last_w;
  logic [7:0]  out_w [3];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  codes_bin2ascii_stream #(.p_nbits(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(in_val_r[0]), .in_rdy(in_rdy_w[0]),
    .in_(in_bus[3:0]), .zpad(zpad_r), .out_val(out_val_w[0]), .out_rdy(out_rdy),
    .out(out_w[0]), .out_last(out_last_w[0]));

  codes_bin2ascii_stream #(.p_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .in_val(in_val_r[1]), .in_rdy(in_rdy_w[1]),
    .in_(in_bus[7:0]), .zpad(zpad_r), .out_val(out_val_w[1]), .out_rdy(out_rdy),
    .out(out_w[1]), .out_last(out_last_w[1]));

  codes_bin2ascii_stream #(.p_nbits(16)) dut16 (
    .clk(clk), .reset(reset), .in_val(in_val_r[2]), .in_rdy(in_rdy_w[2]),
    .in_(in_bus), .zpad(zpad_r), .out_val(out_val_w[2]), .out_rdy(out_rdy),
    .out(out_w[2]), .out_last(out_last_w[2]));

  function automatic int nbits_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 16;
  endfunction

  // Decimal digit count of the largest p_nbits value, by repeated division.
  function automatic int nd_of(input int nbits);
    longint m = (longint'(1) << nbits) - 1;
    int n = 0;
    do begin
      n++;
      m = m / 10;
    end while (m > 0);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sends one value into instance k and checks latency, every character, and
  // the return to idle. stall_first holds out_rdy low on the first character;
  // rand_bp adds random backpressure on every character.
  task automatic run(input int k, input int unsigned value, input bit zp,
                     input int stall_first, input bit rand_bp, input string tag);
    int  exp_q[$];
    int  v;
    int  lat;
    int  tries;
    bit  ok;
    bit  rdy;
    v = int'(value);
    do begin
      exp_q.push_front(v % 10);
      v = v / 10;
    end while (v > 0);
    if (zp) while (exp_q.size() < nd_of(nbits_of(k))) exp_q.push_front(0);

    @(negedge clk);
    for (int w = 0; w < 50 && !in_rdy_w[k]; w++) @(negedge clk);
    check({tag, " in_rdy before send"}, in_rdy_w[k], 1);
    in_bus      = value[15:0];
    zpad_r      = zp;
    in_val_r[k] = 1'b1;
    @(posedge clk);
    #1 in_val_r[k] = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_val_w[k]) begin
        ok = 1'b1;
        break;
      end
      check({tag, " in_rdy low while converting"}, in_rdy_w[k], 0);
      @(posedge clk);
      lat++;
    end
    if (!ok) begin
      check({tag, " out_val timeout"}, 0, 1);
      return;
    end
    check({tag, " latency edges"}, lat, nbits_of(k) + 1);

    foreach (exp_q[i]) begin
      tries = 0;
      forever begin
        check($sformatf("%s char%0d val", tag, i), out_val_w[k], 1);
        check($sformatf("%s char%0d out", tag, i), out_w[k], 8'h30 + exp_q[i]);
        check($sformatf("%s char%0d last", tag, i), out_last_w[k], (i == exp_q.size() - 1));
        check($sformatf("%s char%0d in_rdy", tag, i), in_rdy_w[k], 0);
        if (i == 0 && tries < stall_first) rdy = 1'b0;
        else if (rand_bp && tries < 3)     rdy = 1'($urandom_range(0, 1));
        else                               rdy = 1'b1;
        out_rdy = rdy;
        @(posedge clk);
        @(negedge clk);
        tries++;
        if (rdy) break;
      end
    end
    out_rdy = 1'b1;
    check({tag, " idle out_val"}, out_val_w[k], 0);
    check({tag, " idle out"}, out_w[k], 8'h00);
    check({tag, " idle out_last"}, out_last_w[k], 0);
    check({tag, " idle in_rdy"}, in_rdy_w[k], 1);
  endtask

  // Pulses reset for one cycle on instance 8 and confirms nothing is emitted.
  task automatic pulse_reset(input string tag);
    int seen;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, " out_val in reset"}, out_val_w[1], 0);
    check({tag, " out in reset"}, out_w[1], 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({tag, " in_rdy after reset"}, in_rdy_w[1], 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_val_w[1]) seen++;
    end
    check({tag, " no chars after reset"}, seen, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_val_r = '0;
    in_bus   = '0;
    zpad_r   = 1'b0;
    out_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d in_rdy", k), in_rdy_w[k], 1);
      check($sformatf("reset%0d out_val", k), out_val_w[k], 0);
      check($sformatf("reset%0d out", k), out_w[k], 8'h00);
      check($sformatf("reset%0d out_last", k), out_last_w[k], 0);
    end

    run(1, 0, 1'b0, 0, 1'b0, "w8 zero nopad");
    run(1, 0, 1'b1, 0, 1'b0, "w8 zero pad");
    run(1, 255, 1'b0, 0, 1'b0, "w8 255");
    run(1, 7, 1'b0, 0, 1'b0, "w8 7");
    run(1, 120, 1'b0, 3, 1'b0, "w8 120 stall");
    for (int v = 0; v < 16; v++) run(0, v, 1'b1, 0, 1'b0, $sformatf("w4 sweep %0d", v));
    run(2, 65535, 1'b0, 0, 1'b0, "w16 max");
    run(2, 100, 1'b0, 0, 1'b0, "w16 100");

    // Reset during conversion.
    @(negedge clk);
    in_bus      = 16'd200;
    zpad_r      = 1'b0;
    in_val_r[1] = 1'b1;
    @(posedge clk);
    #1 in_val_r[1] = 1'b0;
    repeat (3) @(posedge clk);
    pulse_reset("rst conv");

    // Reset after one character has been emitted.
    @(negedge clk);
    in_bus      = 16'd255;
    zpad_r      = 1'b1;
    in_val_r[1] = 1'b1;
    @(posedge clk);
    #1 in_val_r[1] = 1'b0;
    for (int c = 0; c < 50 && !out_val_w[1]; c++) @(negedge clk);
    check("rst emit reached EMIT", out_val_w[1], 1);
    @(posedge clk);
    pulse_reset("rst emit");

    run(1, 42, 1'b0, 0, 1'b0, "w8 42 after reset");

    for (int r = 0; r < 20; r++) begin
      run(1, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 0, 1'b1, $sformatf("w8 rand%0d", r));
      run(2, $urandom_range(0, 65535), 1'($urandom_range(0, 1)), 0, 1'b1, $sformatf("w16 rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/codes_bin2ascii_stream.md
# codes_bin2ascii_stream

Parametrised sequential converter from a p_nbits-wide unsigned binary value to its ASCII decimal representation. Characters are streamed out most-significant digit first, one per handshake. Input and output both use val/rdy. The block generalises the fixed 4-bit, 2-character combinational bin2ascii encoder to any width and adds optional leading-zero suppression. It sits between numeric datapaths and character-oriented sinks such as UART/console streams.

## Interface
- p_nbits, default 8: input value width, ≥ 1.
- ND (derived localparam, not overridable): decimal digit count of 2^p_nbits−1. Examples: 4→2, 8→3, 16→5, 32→10.
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  input value valid
- in_rdy  output  1  block can accept a value
- in_  input  p_nbits  unsigned binary value
- zpad  input  1  sampled with in_. 1 = emit all ND digits; 0 = suppress leading zeros, always emitting at least one digit.
- out_val  output  1  character valid
- out_rdy  input  1  sink accepts character
- out  output  8  ASCII character, 8'h30–8'h39
- out_last  output  1  marks the final character of the current value

## Operation
- One clock, clk. Reset is asynchronous and active-high.
- FSM states: IDLE, CONV, EMIT. Reset forces IDLE.
- Reset values:
  - in_rdy=1 (after reset deasserts; no handshake is recognised while reset is high)
  - out_val=0, out=8'h00, out_last=0
  - shift/BCD registers cleared
- IDLE:
  - in_rdy=1.
  - On in_val&in_rdy: load in_ into the binary shift register, clear the ND×4-bit BCD register, latch zpad, clear the step counter, go to CONV.
- CONV:
  - in_rdy=0, out_val=0.
  - Each cycle performs one double-dabble step: every BCD digit ≥5 gets +3, then {bcd,bin} shifts left by 1.
  - After exactly p_nbits steps, go to EMIT.
  - On the transition, the digit pointer is set to:
    - ND−1 if zpad=1;
    - otherwise the index of the most-significant non-zero digit, or 0 if the value is 0.
- EMIT:
  - out_val=1, out=8'h30+bcd[ptr], out_last=(ptr==0).
  - On out_val&out_rdy: if ptr==0, go to IDLE; else decrement ptr.
  - While out_rdy=0, out, out_last and ptr hold stable.
- out drives 8'h00 and out_last drives 0 whenever out_val=0.
- in_val while not IDLE is ignored. The value is not captured.
- Reset asserted in any state aborts the value immediately. No further characters are emitted.

## Timing
- Acceptance edge = E0. Shift steps occur on edges E1..Ep_nbits. The EMIT state and out_val=1 are visible in the cycle after edge Ep_nbits.
- Each character takes ≥1 cycle. With out_rdy held at 1, characters appear on consecutive cycles.
- in_rdy rises in the cycle after the edge that accepts the out_last character. There is no input/output overlap or bypass.
- Minimum period per value: 1 + p_nbits + (digits emitted) cycles.
- in_rdy, out_val, out and out_last are functions of registered state only. No combinational in→out path.

## Structure
- Package codes_bin2ascii_pkg:
  - state enum {IDLE, CONV, EMIT}
  - constant ASCII_ZERO=8'h30
  - function ndigits(nbits), which computes ND
- Sub-module codes_bcd_add3_step, parametrised by ND: combinational add-3 correction across all digits (generate loop). Instantiated once; the parent does the shift.
- The step counter is $clog2(p_nbits+1) bits wide. ptr is $clog2(ND) bits wide, minimum 1.

## Test plan
- p_nbits=8, in_=0, zpad=0 → single char 8'h30, out_last=1. Then in_=0, zpad=1 → 8'h30, 8'h30, 8'h30, with out_last only on the third.
- p_nbits=8, in_=255, zpad=0 → 8'h32, 8'h35, 8'h35. First out_val appears 9 cycles after the acceptance edge. in_=7, zpad=0 → 8'h37 only.
- p_nbits=4, zpad=1, sweep in_=0..15 → {out0,out1} equals the 2-char ASCII code (e.g. 15 → 8'h31, 8'h35; 9 → 8'h30, 8'h39).
- Backpressure, p_nbits=8, in_=120: hold out_rdy=0 for 3 cycles in EMIT → out stays 8'h31 with out_last=0. Release → 8'h32, 8'h30. in_rdy stays 0 until after the final character.
- p_nbits=16, in_=65535 → 8'h36, 8'h35, 8'h35, 8'h33, 8'h35. in_=100, zpad=0 → 8'h31, 8'h30, 8'h30.
- Assert reset for 1 cycle during CONV and again mid-EMIT → out_val=0 immediately, in_rdy=1 after release. A following in_=42, zpad=0 yields 8'h34, 8'h32 correctly.
